// File: rtl/ddr_rd_sched_pkg.sv
// ddr_rd_sched_pkg
//   Shared types and geometry helpers for the DDR line-fetch scheduler.
//   - sched_state_e      : scheduler states (IDLE / ISSUE / WAIT_DATA / DRAIN)
//   - beats_half()       : DDR beats needed for one half-line (RGB565 pixels)
//   - half_row_words()   : words occupied by one half-line in a channel frame
//   - bursts_per_half()  : read commands per half-line
//   - last_burst_len()   : beats carried by the final (possibly short) burst
//   Default-geometry constants BEATS_HALF / HALF_ROW_WORDS are provided for
//   reference; the modules recompute them from their own parameters.
package ddr_rd_sched_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DATA = 2'd2,
      DRAIN     = 2'd3
   } sched_state_e;

   localparam int PIXEL_BITS     = 32'sd16;
   localparam int WORDS_PER_BEAT = 32'sd8;

   function automatic int beats_half(input int h_width, input int dq_width);
      return ((h_width / 32'sd2) * PIXEL_BITS) / (dq_width * 32'sd8);
   endfunction

   function automatic int half_row_words(input int h_width, input int dq_width);
      return ((h_width / 32'sd2) * PIXEL_BITS) / dq_width;
   endfunction

   function automatic int bursts_per_half(input int beats, input int burst_len);
      return (beats + burst_len - 32'sd1) / burst_len;
   endfunction

   // A remainder of zero means every burst, including the last, is full length.
   function automatic int last_burst_len(input int beats, input int burst_len);
      int rem;
      rem = beats % burst_len;
      return (rem == 32'sd0) ? burst_len : rem;
   endfunction

   localparam int BEATS_HALF     = beats_half(32'sd1280, 32'sd32);
   localparam int HALF_ROW_WORDS = half_row_words(32'sd1280, 32'sd32);

endpackage

// File: rtl/ddr_rd_addr_gen.sv
// ddr_rd_addr_gen
//   Registered read-command address/length generator. When load is high the
//   command for (bank, row, half, burst) is computed and held until the next
//   load, so the command stays stable while the DDR port back-pressures.
//   Ports:
//     clk, rst        clock, async active-high reset
//     load            capture a new command this cycle
//     bank            ping-pong frame bank
//     row             output display row 0..H_HEIGHT-1
//     half            0 = left half-line, 1 = right half-line
//     burst           burst index within the half-line
//     addr, len       registered command address (words) and beats-1
module ddr_rd_addr_gen
   import ddr_rd_sched_pkg::*;
#(
   parameter int                DQ_WIDTH     = 32,
   parameter int                H_WIDTH      = 1280,
   parameter int                H_HEIGHT     = 720,
   parameter int                ADDR_W       = 28,
   parameter int                BURST_LEN    = 16,
   parameter logic [ADDR_W-1:0] FRAME_STRIDE = 28'h0100000,
   parameter logic [ADDR_W-1:0] CH0_BASE     = 28'h0000000,
   parameter logic [ADDR_W-1:0] CH1_BASE     = 28'h0400000,
   parameter logic [ADDR_W-1:0] CH2_BASE     = 28'h0800000,
   parameter logic [ADDR_W-1:0] CH3_BASE     = 28'h0C00000
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              bank,
   input  logic [10:0]       row,
   input  logic              half,
   input  logic [7:0]        burst,
   output logic [ADDR_W-1:0] addr,
   output logic [7:0]        len
);

   localparam int                BEATS       = beats_half(H_WIDTH, DQ_WIDTH);
   localparam int                NBURST      = bursts_per_half(BEATS, BURST_LEN);
   localparam logic [ADDR_W-1:0] ROW_WORDS   = ADDR_W'(half_row_words(H_WIDTH, DQ_WIDTH));
   localparam logic [ADDR_W-1:0] BURST_WORDS = ADDR_W'(BURST_LEN * WORDS_PER_BEAT);
   localparam logic [7:0]        LEN_FULL    = 8'(BURST_LEN - 32'sd1);
   localparam logic [7:0]        LEN_LAST    = 8'(last_burst_len(BEATS, BURST_LEN) - 32'sd1);
   localparam logic [7:0]        LAST_IDX    = 8'(NBURST - 32'sd1);
   localparam logic [10:0]       HALF_H      = 11'(H_HEIGHT / 32'sd2);

   logic              bottom_s;
   logic [10:0]       src_row_s;
   logic [ADDR_W-1:0] base_s;
   logic [ADDR_W-1:0] addr_nxt_s;
   logic [7:0]        len_nxt_s;

   // Map the output row onto a quadrant channel and its local row, then form the word address
   always_comb begin
      bottom_s  = (row >= HALF_H);
      src_row_s = bottom_s ? (row - HALF_H) : row;
      case ({bottom_s, half})
         2'b00:   base_s = CH0_BASE;
         2'b01:   base_s = CH1_BASE;
         2'b10:   base_s = CH2_BASE;
         2'b11:   base_s = CH3_BASE;
         default: base_s = CH0_BASE;
      endcase
      addr_nxt_s = base_s
                 + (bank ? FRAME_STRIDE : {ADDR_W{1'b0}})
                 + (ADDR_W'(src_row_s) * ROW_WORDS)
                 + (ADDR_W'(burst) * BURST_WORDS);
      len_nxt_s  = (burst == LAST_IDX) ? LEN_LAST : LEN_FULL;
   end

   // Command register: only changes on load, so it holds through back-pressure
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr <= {ADDR_W{1'b0}};
         len  <= 8'd0;
      end else if (load) begin
         addr <= addr_nxt_s;
         len  <= len_nxt_s;
      end else begin
         addr <= addr;
         len  <= len;
      end
   end

endmodule

// File: rtl/ddr_rd_line_sched.sv
// ddr_rd_line_sched
//   Line-fetch scheduler for the 2x2 spliced HDMI output. Each display line
//   request issues DDR read bursts for the left half-line (channel 0 or 2)
//   and then the right half-line (channel 1 or 3) from the active ping-pong
//   frame bank, and counts returned beats to signal line completion.
//   Optional feature macro RD_SCHED_UNDERRUN_CNT_EN adds underrun_cnt, a
//   saturating count of dropped requests (cleared by rst only).
//   Ports:
//     clk, rst                       clock, async active-high reset
//     fsync, line_req, frame_sel     frame start, line request, bank select
//     rd_cmd_valid/ready/addr/len    DDR read command channel
//     rd_data_valid                  one returned beat
//     line_done                      pulse, all beats of the line returned
//     busy                           line in progress or draining
//     cur_row                        row being / next to be fetched
//     underrun                       pulse, line request dropped
//     underrun_cnt                   (RD_SCHED_UNDERRUN_CNT_EN only)
module ddr_rd_line_sched
   import ddr_rd_sched_pkg::*;
#(
   parameter int                DQ_WIDTH     = 32,
   parameter int                H_WIDTH      = 1280,
   parameter int                H_HEIGHT     = 720,
   parameter int                ADDR_W       = 28,
   parameter int                BURST_LEN    = 16,
   parameter logic [ADDR_W-1:0] FRAME_STRIDE = 28'h0100000,
   parameter logic [ADDR_W-1:0] CH0_BASE     = 28'h0000000,
   parameter logic [ADDR_W-1:0] CH1_BASE     = 28'h0400000,
   parameter logic [ADDR_W-1:0] CH2_BASE     = 28'h0800000,
   parameter logic [ADDR_W-1:0] CH3_BASE     = 28'h0C00000
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              fsync,
   input  logic              line_req,
   input  logic              frame_sel,
   output logic              rd_cmd_valid,
   input  logic              rd_cmd_ready,
   output logic [ADDR_W-1:0] rd_cmd_addr,
   output logic [7:0]        rd_cmd_len,
   input  logic              rd_data_valid,
   output logic              line_done,
   output logic              busy,
   output logic [10:0]       cur_row,
   output logic              underrun
`ifdef RD_SCHED_UNDERRUN_CNT_EN
  ,output logic [15:0]       underrun_cnt
`endif
);

   localparam int          BEATS    = beats_half(H_WIDTH, DQ_WIDTH);
   localparam int          NBURST   = bursts_per_half(BEATS, BURST_LEN);
   localparam logic [7:0]  LAST_IDX = 8'(NBURST - 32'sd1);
   localparam logic [10:0] LAST_ROW = 11'(H_HEIGHT - 32'sd1);

   sched_state_e state_r;
   logic         valid_r;
   logic         half_r;
   logic [7:0]   burst_r;
   logic         bank_r;
   logic [10:0]  row_r;
   logic         pending_r;
   logic [15:0]  outstanding_r;
   logic         line_done_r;
   logic         busy_r;
   logic         underrun_r;

   logic         fire_s;
   logic         last_cmd_s;
   logic         beat_s;
   logic         start_s;
   logic [15:0]  out_nxt_s;
   logic         gen_load_s;
   logic         gen_half_s;
   logic [7:0]   gen_burst_s;
   logic [10:0]  gen_row_s;
   logic         gen_bank_s;

   // Handshake decode and selection of the command the generator loads next
   always_comb begin
      fire_s     = valid_r & rd_cmd_ready;
      last_cmd_s = half_r & (burst_r == LAST_IDX);
      // Beats arriving with nothing outstanding are stale and ignored.
      beat_s     = rd_data_valid & (outstanding_r != 16'd0);
      out_nxt_s  = outstanding_r
                 + (fire_s ? ({8'd0, rd_cmd_len} + 16'd1) : 16'd0)
                 - (beat_s ? 16'd1 : 16'd0);
      // fsync is applied before a same-cycle request, so that request fetches line 0.
      start_s    = (state_r == IDLE) & (line_req | (pending_r & ~fsync));
      gen_row_s  = fsync ? 11'd0 : row_r;
      gen_bank_s = fsync ? frame_sel : bank_r;
      gen_load_s  = 1'b0;
      gen_half_s  = half_r;
      gen_burst_s = burst_r;
      if (start_s) begin
         gen_load_s  = 1'b1;
         gen_half_s  = 1'b0;
         gen_burst_s = 8'd0;
      end else if ((state_r == ISSUE) & fire_s & ~last_cmd_s & ~fsync) begin
         gen_load_s = 1'b1;
         if (burst_r == LAST_IDX) begin
            gen_half_s  = 1'b1;
            gen_burst_s = 8'd0;
         end else begin
            gen_burst_s = burst_r + 8'd1;
         end
      end else begin
         gen_load_s = 1'b0;
      end
   end

   ddr_rd_addr_gen #(
      .DQ_WIDTH     (DQ_WIDTH),
      .H_WIDTH      (H_WIDTH),
      .H_HEIGHT     (H_HEIGHT),
      .ADDR_W       (ADDR_W),
      .BURST_LEN    (BURST_LEN),
      .FRAME_STRIDE (FRAME_STRIDE),
      .CH0_BASE     (CH0_BASE),
      .CH1_BASE     (CH1_BASE),
      .CH2_BASE     (CH2_BASE),
      .CH3_BASE     (CH3_BASE)
   ) u_addr_gen (
      .clk   (clk),
      .rst   (rst),
      .load  (gen_load_s),
      .bank  (gen_bank_s),
      .row   (gen_row_s),
      .half  (gen_half_s),
      .burst (gen_burst_s),
      .addr  (rd_cmd_addr),
      .len   (rd_cmd_len)
   );

   // Scheduler FSM with frame bookkeeping, request queueing and registered status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= IDLE;
         valid_r       <= 1'b0;
         half_r        <= 1'b0;
         burst_r       <= 8'd0;
         bank_r        <= 1'b0;
         row_r         <= 11'd0;
         pending_r     <= 1'b0;
         outstanding_r <= 16'd0;
         line_done_r   <= 1'b0;
         busy_r        <= 1'b0;
         underrun_r    <= 1'b0;
      end else begin
         line_done_r   <= 1'b0;
         underrun_r    <= 1'b0;
         outstanding_r <= out_nxt_s;

         if (fsync) begin
            row_r  <= 11'd0;
            bank_r <= frame_sel;
         end

         // One request may wait while a line is busy; a second one is dropped.
         if (start_s) begin
            pending_r <= line_req & pending_r & ~fsync;
         end else if (line_req) begin
            if (pending_r & ~fsync) begin
               underrun_r <= 1'b1;
            end else begin
               pending_r <= 1'b1;
            end
         end else if (fsync) begin
            pending_r <= 1'b0;
         end

         case (state_r)
            IDLE: begin
               if (start_s) begin
                  state_r <= ISSUE;
                  valid_r <= 1'b1;
                  half_r  <= 1'b0;
                  burst_r <= 8'd0;
                  busy_r  <= 1'b1;
               end else begin
                  busy_r  <= 1'b0;
               end
            end
            ISSUE: begin
               if (fsync) begin
                  // A transfer in this cycle is still counted so its beats drain.
                  state_r <= DRAIN;
                  valid_r <= 1'b0;
               end else if (fire_s) begin
                  if (last_cmd_s) begin
                     state_r <= WAIT_DATA;
                     valid_r <= 1'b0;
                  end else begin
                     half_r  <= gen_half_s;
                     burst_r <= gen_burst_s;
                  end
               end
               busy_r <= 1'b1;
            end
            WAIT_DATA: begin
               if (fsync) begin
                  state_r <= DRAIN;
                  busy_r  <= 1'b1;
               end else if (beat_s && (outstanding_r == 16'd1)) begin
                  state_r     <= IDLE;
                  line_done_r <= 1'b1;
                  busy_r      <= 1'b0;
                  row_r       <= (row_r == LAST_ROW) ? 11'd0 : (row_r + 11'd1);
               end else begin
                  busy_r <= 1'b1;
               end
            end
            DRAIN: begin
               if (out_nxt_s == 16'd0) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  busy_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               valid_r <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

`ifdef RD_SCHED_UNDERRUN_CNT_EN
   logic [15:0] underrun_cnt_r;

   // Saturating count of dropped line requests
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         underrun_cnt_r <= 16'd0;
      end else if (underrun_r && (underrun_cnt_r != 16'hFFFF)) begin
         underrun_cnt_r <= underrun_cnt_r + 16'd1;
      end else begin
         underrun_cnt_r <= underrun_cnt_r;
      end
   end

   assign underrun_cnt = underrun_cnt_r;
`endif

   assign rd_cmd_valid = valid_r;
   assign line_done    = line_done_r;
   assign busy         = busy_r;
   assign cur_row      = row_r;
   assign underrun     = underrun_r;

endmodule

// File: tb/tb_ddr_rd_line_sched.sv
// tb_ddr_rd_line_sched
//   Scoreboard bench for ddr_rd_line_sched: expected commands and line
//   completions are queued when a line request is driven and compared as the
//   DUT issues commands / signals line_done. Beats are returned by the bench
//   for every accepted command. Honours RD_SCHED_UNDERRUN_CNT_EN.
module tb_ddr_rd_line_sched;

   localparam int ADDR_W = 28;

   logic              clk = 1'b0;
   logic              rst;
   logic              fsync;
   logic              line_req;
   logic              frame_sel;
   logic              rd_cmd_valid;
   logic              rd_cmd_ready;
   logic [ADDR_W-1:0] rd_cmd_addr;
   logic [7:0]        rd_cmd_len;
   logic              rd_data_valid;
   logic              line_done;
   logic              busy;
   logic [10:0]       cur_row;
   logic              underrun;
`ifdef RD_SCHED_UNDERRUN_CNT_EN
   logic [15:0]       underrun_cnt;
`endif

   always #5 clk = ~clk;

   ddr_rd_line_sched dut (
      .clk           (clk),
      .rst           (rst),
      .fsync         (fsync),
      .line_req      (line_req),
      .frame_sel     (frame_sel),
      .rd_cmd_valid  (rd_cmd_valid),
      .rd_cmd_ready  (rd_cmd_ready),
      .rd_cmd_addr   (rd_cmd_addr),
      .rd_cmd_len    (rd_cmd_len),
      .rd_data_valid (rd_data_valid),
      .line_done     (line_done),
      .busy          (busy),
      .cur_row       (cur_row),
      .underrun      (underrun)
`ifdef RD_SCHED_UNDERRUN_CNT_EN
     ,.underrun_cnt  (underrun_cnt)
`endif
   );

   typedef struct packed {
      logic [27:0] addr;
      logic [7:0]  len;
   } cmd_t;

   cmd_t cmd_q[$];
   int   done_q[$];

   int n_checks    = 0;
   int n_fail      = 0;
   int owed        = 0;
   int beat_budget = 1000000;
   int line_beats  = 0;
   int done_cnt    = 0;
   int urun_seen   = 0;
   int urun_exp    = 0;
   bit rand_beats  = 1'b0;
   bit done_flag   = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference address: quadrant base + bank stride + local row * 320 + burst * 128
   function automatic logic [27:0] model_addr(input logic bank, input int row, input logic half, input int burst);
      logic [27:0] base;
      int          srow;
      if (row < 360) begin
         base = half ? 28'h0400000 : 28'h0000000;
         srow = row;
      end else begin
         base = half ? 28'h0C00000 : 28'h0800000;
         srow = row - 360;
      end
      return base + (bank ? 28'h0100000 : 28'h0000000) + 28'(srow * 320) + 28'(burst * 128);
   endfunction

   task automatic push_line(input logic bank, input int row, input bit expect_done);
      for (int h = 0; h < 2; h++) begin
         for (int b = 0; b < 3; b++) begin
            cmd_q.push_back(cmd_t'{addr: model_addr(bank, row, (h == 1), b), len: (b == 2) ? 8'd7 : 8'd15});
         end
      end
      if (expect_done) done_q.push_back((row + 1) % 720);
   endtask

   // One clock: sample at negedge, then drive the next inputs just after posedge
   task automatic cycle();
      cmd_t e;
      @(negedge clk);
      if (rd_cmd_valid && rd_cmd_ready) begin
         if (cmd_q.size() == 0) begin
            check_eq("cmd_extra", {4'h0, rd_cmd_addr}, 32'hFFFFFFFF);
         end else begin
            e = cmd_q.pop_front();
            check_eq("cmd_addr", 32'(rd_cmd_addr), 32'(e.addr));
            check_eq("cmd_len", 32'(rd_cmd_len), 32'(e.len));
         end
         owed += int'(rd_cmd_len) + 1;
      end
      if (rd_data_valid) line_beats++;
      if (underrun) urun_seen++;
      if (line_done) begin
         done_cnt++;
         done_flag = 1'b1;
         if (done_q.size() == 0) begin
            check_eq("done_extra", 32'(cur_row), 32'hFFFFFFFF);
         end else begin
            check_eq("done_row", 32'(cur_row), 32'(done_q.pop_front()));
         end
         check_eq("done_beats", 32'(line_beats), 32'd80);
         line_beats = 0;
      end
      @(posedge clk);
      #1;
      fsync    = 1'b0;
      line_req = 1'b0;
      if (owed > 0 && beat_budget > 0 && (!rand_beats || $urandom_range(0, 3) != 0)) begin
         rd_data_valid = 1'b1;
         owed--;
         beat_budget--;
      end else begin
         rd_data_valid = 1'b0;
      end
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      done_flag = 1'b0;
      while (!done_flag && n < budget) begin
         cycle();
         n++;
      end
      check_eq("done_timeout", 32'(done_flag), 32'd1);
   endtask

   initial begin
      int n;
      int dc;
      rst           = 1'b1;
      fsync         = 1'b0;
      line_req      = 1'b0;
      frame_sel     = 1'b0;
      rd_cmd_ready  = 1'b1;
      rd_data_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_valid", 32'(rd_cmd_valid), 32'd0);
      check_eq("rst_addr", 32'(rd_cmd_addr), 32'd0);
      check_eq("rst_len", 32'(rd_cmd_len), 32'd0);
      check_eq("rst_done", 32'(line_done), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_row", 32'(cur_row), 32'd0);
      check_eq("rst_urun", 32'(underrun), 32'd0);
      rst = 1'b0;
      cycle();

      // First line, bank 0: literal command list
      frame_sel = 1'b0;
      fsync     = 1'b1;
      cycle();
      cmd_q.push_back(cmd_t'{addr: 28'h0000000, len: 8'd15});
      cmd_q.push_back(cmd_t'{addr: 28'h0000080, len: 8'd15});
      cmd_q.push_back(cmd_t'{addr: 28'h0000100, len: 8'd7});
      cmd_q.push_back(cmd_t'{addr: 28'h0400000, len: 8'd15});
      cmd_q.push_back(cmd_t'{addr: 28'h0400080, len: 8'd15});
      cmd_q.push_back(cmd_t'{addr: 28'h0400100, len: 8'd7});
      done_q.push_back(1);
      line_req = 1'b1;
      cycle();
      check_eq("latency_valid", 32'(rd_cmd_valid), 32'd1);
      wait_done(300);
      check_eq("idle_after_done_busy", 32'(busy), 32'd0);
      check_eq("idle_after_done_valid", 32'(rd_cmd_valid), 32'd0);

      // Full bank-1 frame: rows 0..719 incl. quadrant switch at 360 and wrap
      frame_sel = 1'b1;
      fsync     = 1'b1;
      cycle();
      check_eq("fsync_row", 32'(cur_row), 32'd0);
      for (int r = 0; r < 720; r++) begin
         push_line(1'b1, r, 1'b1);
         line_req = 1'b1;
         cycle();
         wait_done(300);
      end
      check_eq("wrap_row", 32'(cur_row), 32'd0);

      // Pending request and underrun
      rand_beats = 1'b1;
      push_line(1'b1, 0, 1'b1);
      push_line(1'b1, 1, 1'b1);
      urun_exp++;
      line_req = 1'b1;
      cycle();
      repeat (3) cycle();
      check_eq("busy_in_line", 32'(busy), 32'd1);
      line_req = 1'b1;
      cycle();
      repeat (2) cycle();
      line_req = 1'b1;
      cycle();
      wait_done(400);
      check_eq("pend_start", 32'(rd_cmd_valid), 32'd1);
      wait_done(400);
      check_eq("urun_pulses", 32'(urun_seen), 32'(urun_exp));
      rand_beats = 1'b0;

      // fsync after two accepted commands and 20 returned beats
      rd_cmd_ready = 1'b0;
      line_beats   = 0;
      cmd_q.push_back(cmd_t'{addr: model_addr(1'b1, 2, 1'b0, 0), len: 8'd15});
      cmd_q.push_back(cmd_t'{addr: model_addr(1'b1, 2, 1'b0, 1), len: 8'd15});
      line_req = 1'b1;
      cycle();
      rd_cmd_ready = 1'b1;
      cycle();
      cycle();
      rd_cmd_ready = 1'b0;
      beat_budget  = 20;
      n = 0;
      while (line_beats < 20 && n < 100) begin
         cycle();
         n++;
      end
      check_eq("drain_pre_beats", 32'(line_beats), 32'd20);
      dc        = done_cnt;
      frame_sel = 1'b0;
      fsync     = 1'b1;
      beat_budget = 1000000;
      cycle();
      check_eq("drain_valid", 32'(rd_cmd_valid), 32'd0);
      check_eq("drain_busy", 32'(busy), 32'd1);
      check_eq("drain_row", 32'(cur_row), 32'd0);
      n = 0;
      while (busy && n < 200) begin
         cycle();
         n++;
      end
      check_eq("drain_idle", 32'(busy), 32'd0);
      check_eq("drain_beats", 32'(line_beats), 32'd32);
      check_eq("drain_no_done", 32'(done_cnt), 32'(dc));
      line_beats   = 0;
      rd_cmd_ready = 1'b1;

      // fsync and line_req together: bank 1, line 0
      frame_sel = 1'b1;
      fsync     = 1'b1;
      line_req  = 1'b1;
      push_line(1'b1, 0, 1'b1);
      cycle();
      wait_done(300);

      // Back-pressure on the second command: held stable, no duplicate
      push_line(1'b1, 1, 1'b1);
      line_req = 1'b1;
      cycle();
      cycle();
      rd_cmd_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cycle();
         check_eq("hold_valid", 32'(rd_cmd_valid), 32'd1);
         check_eq("hold_addr", 32'(rd_cmd_addr), 32'(model_addr(1'b1, 1, 1'b0, 1)));
         check_eq("hold_len", 32'(rd_cmd_len), 32'd15);
      end
      rd_cmd_ready = 1'b1;
      wait_done(300);
      check_eq("end_row", 32'(cur_row), 32'd2);

      repeat (5) cycle();
      check_eq("cmd_q_left", 32'(cmd_q.size()), 32'd0);
      check_eq("done_q_left", 32'(done_q.size()), 32'd0);
      check_eq("urun_final", 32'(urun_seen), 32'(urun_exp));
`ifdef RD_SCHED_UNDERRUN_CNT_EN
      check_eq("urun_cnt", 32'(underrun_cnt), 32'(urun_exp));
`endif
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
